// File: rtl/pipe_pkg.sv
// pipe_pkg: shared definitions for the pipeline stage registers.
//   occ_e          - occupancy / state encoding (EMPTY, BUSY, FULL)
//   MEMWB_W        - width of the MEM/WB payload pack
//   MEMWB_*_LSB/W  - field positions inside the MEM/WB pack
//   memwb_pack()   - builds a MEM/WB payload from its fields
package pipe_pkg;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_BUSY  = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  localparam int MEMWB_W = 103;

  // MEM/WB pack layout, MSB first: {WB[1:0], RD[31:0], pc[31:0], ALUout[31:0], WN[4:0]}
  localparam int MEMWB_WN_LSB  = 0;
  localparam int MEMWB_WN_W    = 5;
  localparam int MEMWB_ALU_LSB = MEMWB_WN_LSB + MEMWB_WN_W;
  localparam int MEMWB_ALU_W   = 32;
  localparam int MEMWB_PC_LSB  = MEMWB_ALU_LSB + MEMWB_ALU_W;
  localparam int MEMWB_PC_W    = 32;
  localparam int MEMWB_RD_LSB  = MEMWB_PC_LSB + MEMWB_PC_W;
  localparam int MEMWB_RD_W    = 32;
  localparam int MEMWB_WB_LSB  = MEMWB_RD_LSB + MEMWB_RD_W;
  localparam int MEMWB_WB_W    = 2;

  function automatic logic [MEMWB_W-1:0] memwb_pack(
    input logic [1:0]  wb,
    input logic [31:0] rd,
    input logic [31:0] pc,
    input logic [31:0] alu_out,
    input logic [4:0]  wn
  );
    return {wb, rd, pc, alu_out, wn};
  endfunction

endpackage

// File: rtl/pipe_skid_stage_if.sv
// pipe_skid_stage_if: handshake bundle around one pipeline stage.
//   in_valid/in_ready/in_data    - upstream valid/ready channel
//   out_valid/out_ready/out_data - downstream valid/ready channel
//   flush                        - squash everything held in the stage
//   occupancy                    - number of payloads held (0..2)
// Modports: slave is the stage's view, master is the surrounding pipeline's view.
interface pipe_skid_stage_if
  import pipe_pkg::*;
#(
  parameter int WIDTH = MEMWB_W
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             flush;
  logic [1:0]       occupancy;

  modport slave (
    input  in_valid, in_data, out_ready, flush,
    output in_ready, out_valid, out_data, occupancy
  );

  modport master (
    output in_valid, in_data, out_ready, flush,
    input  in_ready, out_valid, out_data, occupancy
  );

endinterface

// File: rtl/pipe_payload_reg.sv
// pipe_payload_reg: WIDTH-wide payload register.
//   clk   - clock
//   rst   - synchronous active-low reset, zeroes q
//   clear - synchronous zero (lower priority than rst, higher than load)
//   load  - capture d
//   d, q  - data in / data out
module pipe_payload_reg #(
  parameter int WIDTH = 103
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      q <= '0;
    end else if (clear) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: pipeline stage register with valid/ready handshake,
// a 2-entry skid buffer (main + skid), flush and registered in_ready.
//   clk  - clock
//   rst  - synchronous active-low reset
//   bus  - pipe_skid_stage_if.slave: in_valid/in_ready/in_data,
//          out_valid/out_ready/out_data, flush, occupancy
// Parameters: WIDTH (payload bits), CLEAR_ON_FLUSH (zero data on flush).
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int WIDTH          = MEMWB_W,
  parameter bit CLEAR_ON_FLUSH = 1'b1
) (
  input logic              clk,
  input logic              rst,
  pipe_skid_stage_if.slave bus
);

  occ_e             state_q, state_d;
  logic             in_ready_q;
  logic             in_fire, out_fire;
  logic             main_load, main_from_skid, skid_load, data_clear;
  logic [WIDTH-1:0] main_d, main_q, skid_q;

  // Main register is valid in BUSY and FULL; the skid entry only in FULL.
  assign bus.out_valid = (state_q != OCC_EMPTY);
  assign bus.out_data  = main_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.occupancy = state_q;

  assign in_fire  = bus.in_valid & in_ready_q;
  assign out_fire = bus.out_valid & bus.out_ready;

  // Next state and register steering. Flush overrides every transition;
  // an in_fire on the flush cycle is simply never loaded.
  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    data_clear     = 1'b0;
    if (bus.flush) begin
      state_d    = OCC_EMPTY;
      data_clear = CLEAR_ON_FLUSH;
    end else begin
      case (state_q)
        OCC_EMPTY: begin
          if (in_fire) begin
            state_d   = OCC_BUSY;
            main_load = 1'b1;
          end
        end
        OCC_BUSY: begin
          if (in_fire && out_fire) begin
            main_load = 1'b1;
          end else if (in_fire) begin
            // Downstream stalled this cycle: park the new payload in skid.
            state_d   = OCC_FULL;
            skid_load = 1'b1;
          end else if (out_fire) begin
            state_d = OCC_EMPTY;
          end
        end
        OCC_FULL: begin
          if (out_fire) begin
            state_d        = OCC_BUSY;
            main_load      = 1'b1;
            main_from_skid = 1'b1;
          end
        end
        default: state_d = OCC_EMPTY;
      endcase
    end
  end

  assign main_d = main_from_skid ? skid_q : bus.in_data;

  // in_ready is computed from the next state so it never depends on
  // out_ready combinationally; the skid entry covers the one-cycle lag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= OCC_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != OCC_FULL);
    end
  end

  pipe_payload_reg #(.WIDTH(WIDTH)) u_main (
    .clk   (clk),
    .rst   (rst),
    .clear (data_clear),
    .load  (main_load),
    .d     (main_d),
    .q     (main_q)
  );

  pipe_payload_reg #(.WIDTH(WIDTH)) u_skid (
    .clk   (clk),
    .rst   (rst),
    .clear (data_clear),
    .load  (skid_load),
    .d     (bus.in_data),
    .q     (skid_q)
  );

endmodule

// File: tb/tb_pipe_skid_stage.sv
// tb_pipe_skid_stage: directed table-driven bench for pipe_skid_stage.
// Two instances share the same stimulus: dut_clr (CLEAR_ON_FLUSH = 1)
// is fully checked, dut_hold (CLEAR_ON_FLUSH = 0) is additionally checked
// where its data differs after a flush.
module tb_pipe_skid_stage;
  import pipe_pkg::*;

  localparam int W = MEMWB_W;

  localparam logic [W-1:0] PAY_A = 103'hA_AAAA_0000_1111_2222_3333_4444;
  localparam logic [W-1:0] PAY_B = 103'hB_BBBB_5555_6666_7777_8888_9999;
  localparam logic [W-1:0] PAY_C = 103'hC_CCCC_DDDD_EEEE_FFFF_0123_4567;
  localparam logic [W-1:0] PAY_R = 103'h1234;

  typedef struct {
    string        name;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         out_ready;
    logic         flush;
    logic         exp_out_valid;
    logic [W-1:0] exp_out_data;
    logic         exp_in_ready;
    logic [1:0]   exp_occ;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  int n_vectors     = 0;
  int n_miscompares = 0;

  vec_t vecs[$];

  pipe_skid_stage_if #(.WIDTH(W)) bus_clr ();
  pipe_skid_stage_if #(.WIDTH(W)) bus_hold ();

  pipe_skid_stage #(.WIDTH(W), .CLEAR_ON_FLUSH(1'b1)) dut_clr (
    .clk (clk),
    .rst (rst),
    .bus (bus_clr.slave)
  );

  pipe_skid_stage #(.WIDTH(W), .CLEAR_ON_FLUSH(1'b0)) dut_hold (
    .clk (clk),
    .rst (rst),
    .bus (bus_hold.slave)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs to both instances, then sample 1ns after the edge.
  task automatic applyStimulus(input logic r, input logic iv, input logic [W-1:0] id,
                               input logic ordy, input logic fl);
    rst                = r;
    bus_clr.in_valid   = iv;
    bus_clr.in_data    = id;
    bus_clr.out_ready  = ordy;
    bus_clr.flush      = fl;
    bus_hold.in_valid  = iv;
    bus_hold.in_data   = id;
    bus_hold.out_ready = ordy;
    bus_hold.flush     = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic ev, input logic [W-1:0] ed,
                             input logic eir, input logic [1:0] eocc);
    n_vectors++;
    if (bus_clr.out_valid !== ev) begin
      n_miscompares++;
      $display("[TB] FAIL %s out_valid: got %b expected %b", name, bus_clr.out_valid, ev);
    end
    if (bus_clr.out_data !== ed) begin
      n_miscompares++;
      $display("[TB] FAIL %s out_data: got %h expected %h", name, bus_clr.out_data, ed);
    end
    if (bus_clr.in_ready !== eir) begin
      n_miscompares++;
      $display("[TB] FAIL %s in_ready: got %b expected %b", name, bus_clr.in_ready, eir);
    end
    if (bus_clr.occupancy !== eocc) begin
      n_miscompares++;
      $display("[TB] FAIL %s occupancy: got %0d expected %0d", name, bus_clr.occupancy, eocc);
    end
  endtask

  task automatic checkHold(input string name, input logic ev, input logic [W-1:0] ed);
    n_vectors++;
    if (bus_hold.out_valid !== ev) begin
      n_miscompares++;
      $display("[TB] FAIL %s hold out_valid: got %b expected %b", name, bus_hold.out_valid, ev);
    end
    if (bus_hold.out_data !== ed) begin
      n_miscompares++;
      $display("[TB] FAIL %s hold out_data: got %h expected %h", name, bus_hold.out_data, ed);
    end
  endtask

  initial begin
    //              name        rst iv  in_data      ordy fl  ov  out_data     ir  occ
    vecs.push_back('{"reset0",  0, 1, PAY_R,       0, 0,  0, '0,          1, 0});
    vecs.push_back('{"reset1",  0, 1, PAY_R,       0, 0,  0, '0,          1, 0});
    vecs.push_back('{"stream1", 1, 1, 103'd1,      1, 0,  1, 103'd1,      1, 1});
    vecs.push_back('{"stream2", 1, 1, 103'd2,      1, 0,  1, 103'd2,      1, 1});
    vecs.push_back('{"stream3", 1, 1, 103'd3,      1, 0,  1, 103'd3,      1, 1});
    vecs.push_back('{"stream4", 1, 1, 103'd4,      1, 0,  1, 103'd4,      1, 1});
    vecs.push_back('{"drain",   1, 0, 103'd9,      1, 0,  0, 103'd4,      1, 0});
    vecs.push_back('{"stallA",  1, 1, PAY_A,       0, 0,  1, PAY_A,       1, 1});
    vecs.push_back('{"stallB",  1, 1, PAY_B,       0, 0,  1, PAY_A,       0, 2});
    vecs.push_back('{"fullC",   1, 1, PAY_C,       0, 0,  1, PAY_A,       0, 2});
    vecs.push_back('{"leaveA",  1, 0, PAY_C,       1, 0,  1, PAY_B,       1, 1});
    vecs.push_back('{"leaveB",  1, 0, PAY_C,       1, 0,  0, PAY_B,       1, 0});

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].in_valid, vecs[i].in_data,
                    vecs[i].out_ready, vecs[i].flush);
      checkOutput(vecs[i].name, vecs[i].exp_out_valid, vecs[i].exp_out_data,
                  vecs[i].exp_in_ready, vecs[i].exp_occ);
    end

    // Flush while FULL, with C offered on the flush cycle.
    applyStimulus(1, 1, PAY_A, 0, 0);
    checkOutput("flA", 1, PAY_A, 1, 2'd1);
    applyStimulus(1, 1, PAY_B, 0, 0);
    checkOutput("flB", 1, PAY_A, 0, 2'd2);
    applyStimulus(1, 1, PAY_C, 0, 1);
    checkOutput("flush", 0, '0, 1, 2'd0);
    checkHold("flush", 0, PAY_A);
    applyStimulus(1, 0, PAY_C, 1, 0);
    checkOutput("postflush", 0, '0, 1, 2'd0);
    checkHold("postflush", 0, PAY_A);
    // Flush from EMPTY drops an accepted-looking offer.
    applyStimulus(1, 1, PAY_C, 1, 1);
    checkOutput("flushempty", 0, '0, 1, 2'd0);
    checkHold("flushempty", 0, PAY_A);

    // Reset pulse in FULL with downstream ready: nothing held survives.
    applyStimulus(1, 1, PAY_A, 0, 0);
    checkOutput("rsA", 1, PAY_A, 1, 2'd1);
    applyStimulus(1, 1, PAY_B, 0, 0);
    checkOutput("rsB", 1, PAY_A, 0, 2'd2);
    applyStimulus(0, 0, PAY_C, 1, 0);
    checkOutput("midreset", 0, '0, 1, 2'd0);
    checkHold("midreset", 0, '0);
    applyStimulus(1, 0, PAY_C, 1, 0);
    checkOutput("postreset", 0, '0, 1, 2'd0);
    applyStimulus(1, 0, PAY_C, 1, 0);
    checkOutput("postreset2", 0, '0, 1, 2'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule

// File: doc/pipe_skid_stage.md
# pipe_skid_stage

Parametrised pipeline stage register with a valid/ready handshake, a 2-entry skid buffer, flush, and bubble insertion. It is the successor to the fixed-field inter-stage latches, such as the MEM/WB register. Each stage carries an opaque packed payload of WIDTH bits, so one block serves IF/ID, ID/EX, EX/MEM and MEM/WB. Stalls propagate through registered ready signals instead of a global stall wire.

## Interface
- WIDTH, 103: payload width. The default is the MEM/WB pack {WB[1:0], RD[31:0], pc[31:0], ALUout[31:0], WN[4:0]}.
- CLEAR_ON_FLUSH, 1: when 1, a flush also zeroes out_data. A zeroed WB/control field means "no write".
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-low. Sampled on the rising edge of clk.
- in_valid  in  1  upstream has a payload.
- in_ready  out  1  stage can accept; driven directly from a flop.
- in_data  in  WIDTH  upstream payload.
- out_valid  out  1  out_data holds a live payload.
- out_ready  in  1  downstream accepts.
- out_data  out  WIDTH  payload presented downstream; driven from the main register.
- flush  in  1  squash all held payloads (branch mispredict or exception).
- occupancy  out  2  number of held payloads: 0, 1 or 2.

## Operation
- Handshake events:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
- Storage: a main register (out_data/out_valid) and a skid register (skid_data/skid_valid).
- States, encoded by occupancy:
  - EMPTY = 0
  - BUSY = 1: main register valid.
  - FULL = 2: main and skid registers both valid.
- Transitions when flush = 0:
  - EMPTY: in_fire → BUSY, main ← in_data.
  - BUSY, in_fire & out_fire → BUSY, main ← in_data.
  - BUSY, in_fire & !out_fire → FULL, skid ← in_data, main unchanged.
  - BUSY, !in_fire & out_fire → EMPTY.
  - BUSY, no fire → BUSY, hold.
  - FULL: in_ready = 0, so in_fire cannot occur.
  - FULL, out_fire → BUSY, main ← skid.
  - FULL, no fire → hold.
- in_ready next value = !(next state == FULL).
- Flush:
  - Dominates everything: next state EMPTY, out_valid = 0, skid_valid = 0, in_ready = 1.
  - A payload offered on the flush cycle is dropped, even if in_valid & in_ready.
  - A coincident out_fire on the flush cycle still completes downstream; out_data is valid during that cycle.
  - If CLEAR_ON_FLUSH = 1, main and skid data ← 0. Otherwise data holds.
- Stability rule: while out_valid & !out_ready, out_data and out_valid hold, except on flush.
- Order: payloads leave in arrival order; none is duplicated or lost except by flush.

## Timing
- Reset state after an edge with rst = 0:
  - out_valid = 0, out_data = 0
  - skid_valid = 0, skid_data = 0
  - in_ready = 1, occupancy = 0
- Reset asserted mid-operation discards every held payload at that edge, overriding flush and both fires.
- Latency: in_fire at edge N makes the payload visible on out_data at N+1.
- Throughput: one payload per cycle when out_ready is held high. Steady state stays in BUSY.
- Ready timing: in_ready is registered and never depends combinationally on out_ready.
  - It deasserts the cycle after the stage becomes FULL.
  - The skid entry absorbs the one payload accepted in the cycle the stall began.
- Occupancy is registered and reflects the state after the last edge.

## Structure
- Package pipe_pkg holds:
  - occupancy encodings OCC_EMPTY = 2'd0, OCC_BUSY = 2'd1, OCC_FULL = 2'd2
  - localparam MEMWB_W = 103
  - field-offset localparams for the MEM/WB pack, so the WB stage unpacks without magic numbers
- One sub-module: pipe_payload_reg, a WIDTH-wide register with synchronous active-low reset, load enable and clear. It is instantiated twice (main and skid).
- All control (state, in_ready, occupancy) lives in pipe_skid_stage.

## Test plan
- Reset: drive rst = 0 for 2 cycles with in_valid = 1, in_data = 103'h1234 → out_valid = 0, out_data = 0, in_ready = 1, occupancy = 0 after the edge.
- Streaming: out_ready = 1, in_data = 1, 2, 3, 4 on consecutive cycles → out_data = 1, 2, 3, 4 one cycle later each, occupancy stays 1, in_ready stays 1.
- Stall/skid:
  - Send A then B with out_ready = 0 from the cycle A appears → occupancy = 2, in_ready = 0, out_data = A held.
  - Raise out_ready → A, then B, leave on consecutive cycles; in_ready returns to 1 the cycle after A leaves.
- Flush in FULL: hold A (main) and B (skid), assert flush with in_valid = 1, C offered → next cycle occupancy = 0, out_valid = 0, out_data = 0, C never appears.
- CLEAR_ON_FLUSH = 0 variant: the same flush leaves out_data = A while out_valid = 0.
- Reset mid-stall: from FULL, pulse rst = 0 for one cycle while out_ready = 1 → all outputs at reset values, neither A nor B emitted after the edge.
